// File: rtl/seq_cir.sv
// Moore detector: z rises once a and b have been high together on two or more
// consecutive clock edges, and drops on the first edge that breaks the run.
module seq_cir (
    input  logic a,
    input  logic b,
    output logic z,
    input  logic Rst,
    input  logic Clk
);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    state_t state;
    logic   both;

    assign both = a & b;

    // z is registered alongside the state so it always equals (state == S2)
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S0;
            z     <= 1'b0;
        end else begin
            case (state)
                S0: begin
                    state <= both ? S1 : S0;
                    z     <= 1'b0;
                end
                S1: begin
                    state <= both ? S2 : S0;
                    z     <= both;
                end
                S2: begin
                    state <= both ? S2 : S0;
                    z     <= both;
                end
                default: begin
                    state <= S0;
                    z     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_cir.sv
// Bench for seq_cir: directed table of vectors, hand-written multi-cycle
// sequences, and random stimulus against a run-length reference model.
`timescale 1ps/1ps
module tb_seq_cir;

    logic a;
    logic b;
    logic z;
    logic Rst;
    logic Clk;

    int vectors;
    int miscompares;
    int runLength;

    typedef struct {
        logic       rst;
        logic [1:0] ab;
        logic       expZ;
        string      name;
    } vec_t;

    vec_t table_v[$];

    seq_cir dut (
        .a  (a),
        .b  (b),
        .z  (z),
        .Rst(Rst),
        .Clk(Clk)
    );

    initial begin
        Clk = 1'b0;
        forever #100 Clk = ~Clk;
    end

    // Called 1 ps after a rising edge: drives inputs 50 ps after that edge,
    // waits for the next edge, then updates the reference run-length model
    task automatic applyStimulus(input logic r, input logic [1:0] ab);
        #49;
        Rst = r;
        {a, b} = ab;
        @(posedge Clk);
        #1;
        if (r)
            runLength = 0;
        else if (ab == 2'b11)
            runLength = runLength + 1;
        else
            runLength = 0;
    endtask

    task automatic checkOutput(input string name, input logic expected);
        vectors = vectors + 1;
        if (z !== expected) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: z=%b expected %b", name, z, expected);
        end
    endtask

    function automatic logic modelZ();
        return (runLength >= 2) ? 1'b1 : 1'b0;
    endfunction

    task automatic addVec(input logic r, input logic [1:0] ab, input logic e, input string n);
        vec_t v;
        v.rst  = r;
        v.ab   = ab;
        v.expZ = e;
        v.name = n;
        table_v.push_back(v);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        runLength   = 0;
        Rst = 1'b1;
        a   = 1'b0;
        b   = 1'b0;

        addVec(1, 2'b01, 0, "reset_01");
        addVec(0, 2'b01, 0, "idle_01");
        addVec(0, 2'b11, 0, "first_11");
        addVec(0, 2'b11, 1, "second_11");
        addVec(0, 2'b00, 0, "break_00");
        addVec(0, 2'b11, 0, "partial_11");
        addVec(1, 2'b10, 0, "reset_mid_run");
        addVec(0, 2'b11, 0, "restart_11");
        addVec(0, 2'b00, 0, "s1_break_00_a");
        addVec(0, 2'b00, 0, "s1_break_00_b");
        addVec(0, 2'b00, 0, "s1_break_00_c");
        addVec(0, 2'b11, 0, "rerun_11_a");
        addVec(0, 2'b11, 1, "rerun_11_b");
        addVec(0, 2'b01, 0, "break_01");
        addVec(0, 2'b11, 0, "long_run_1");
        addVec(0, 2'b11, 1, "long_run_2");
        addVec(0, 2'b11, 1, "long_run_3");
        addVec(0, 2'b11, 1, "long_run_4");
        addVec(0, 2'b11, 1, "long_run_5");
        addVec(0, 2'b10, 0, "break_10");
        addVec(0, 2'b11, 0, "gap_run_1");
        addVec(0, 2'b10, 0, "gap_break");
        addVec(0, 2'b11, 0, "gap_run_2");
        addVec(0, 2'b11, 1, "gap_run_3");

        @(posedge Clk);
        #1;

        foreach (table_v[i]) begin
            applyStimulus(table_v[i].rst, table_v[i].ab);
            checkOutput(table_v[i].name, table_v[i].expZ);
        end

        // Reset while z is high, with 11 held throughout and after release
        applyStimulus(1, 2'b11);
        checkOutput("rst_from_s2", 0);
        applyStimulus(1, 2'b11);
        checkOutput("rst_hold_11", 0);
        applyStimulus(0, 2'b11);
        checkOutput("release_edge_1", 0);
        applyStimulus(0, 2'b11);
        checkOutput("release_edge_2", 1);
        applyStimulus(0, 2'b11);
        checkOutput("release_edge_3", 1);
        applyStimulus(0, 2'b00);
        checkOutput("release_break", 0);

        // Random stimulus biased toward 11 so long runs actually occur
        for (int i = 0; i < 400; i++) begin
            logic       r;
            logic [1:0] ab;
            r  = ($urandom_range(0, 15) == 0);
            ab = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'($urandom_range(0, 3));
            applyStimulus(r, ab);
            checkOutput("random", modelZ());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_cir.md
# seq_cir

Small synchronous Moore state machine that watches a pair of single-bit inputs `a`, `b` and raises `z` once both inputs have been high together on two or more consecutive clock edges. It is a standalone control primitive: the output is registered and glitch-free, suitable for driving downstream enables directly.

## Interface

- Parameters: none.
- Positional port order is fixed: `a`, `b`, `z`, `Rst`, `Clk`. Instantiations connect by position.
- One clock; reset is synchronous and active-high.
- `Clk`  input  1  Rising-edge clock; the only clock.
- `Rst`  input  1  Synchronous, active-high reset; sampled on the rising edge of `Clk`.
- `a`  input  1  Data input A; sampled on the rising edge of `Clk`.
- `b`  input  1  Data input B; sampled on the rising edge of `Clk`.
- `z`  output  1  Detection flag; registered Moore output.

## Operation

- State register is 2 bits. Encoding: S0=00 (idle), S1=01 (one `11` seen), S2=10 (detected), 11 unused.
- `ab` denotes the sampled input pair {a,b}.
- Transitions, evaluated on each rising `Clk` edge when `Rst`=0:
  - S0: `ab`=11 -> S1; otherwise -> S0.
  - S1: `ab`=11 -> S2; otherwise -> S0.
  - S2: `ab`=11 -> S2 (stays while 11 persists); otherwise -> S0.
  - Unused state 11: -> S0 unconditionally, regardless of `ab`. The machine is self-recovering.
- Output decode: `z`=1 only in S2; `z`=0 in S0, S1 and 11. `z` is decoded from the state register only, never directly from `a` or `b`.
- `ab`=01, 10 and 00 are all treated identically as "not 11". Any of them breaks the run.
- Reset:
  - `Rst`=1 at a rising edge forces S0 (`z`=0), whatever the values of `a`, `b` and the current state.
  - Reset has priority over every transition.
  - Mid-run reset discards the partial count. The next `11` after reset starts at S1.
- Before the first reset edge, state and `z` are undefined. The bench must apply reset before checking `z`.

## Timing

- Inputs must be stable around the rising `Clk` edge. Between edges they may change freely, with no effect.
- Latency from the second consecutive sampled `11` to `z`=1: the edge that samples it updates the state. `z` goes high in the same delta after that edge, which makes it visible for the whole following cycle.
- `z` deasserts at the first edge that samples a non-11 pair or `Rst`=1.
- Minimum `z` pulse width is one clock period. `z` stays high for N−1 cycles when N consecutive `11` samples occur (N≥2).
- No combinational path exists from inputs to `z`.

## Test plan

Inputs change 50 ps after each rising edge; clock period 200 ps; `z` is checked just after each edge.

- Reset, then `ab`=01 -> state S0, `z`=0.
- From S0, drive `ab`=11, 11, 00 -> `z`=0, then 1, then 0 (states S1, S2, S0).
- From S0, drive `ab`=11, then assert `Rst`=1 with `ab`=10, then `ab`=11 -> `z` stays 0 throughout (states S1, S0, S1). This shows the reset discarding the partial run.
- From S1, drive `ab`=00, 00, 00, then 11, 11, then 01 -> `z`=0,0,0,0,1,0.
- From S0, drive `ab`=11 for 5 consecutive edges -> `z` sequence 0,1,1,1,1. On the next edge drive `ab`=10 -> `z`=0.
- Reset with `ab`=11 held throughout -> `z`=0 while `Rst`=1. After release, `z`=0 after the first edge and 1 after the second.
